// File: rtl/ifu_mt.sv
// ifu_fifo: generic FIFO, registered storage, head word visible combinationally.
// Latency: a pushed word reaches the head on the next cycle.
// Backpressure: none internally; the owner must only push into a full FIFO while popping.
module ifu_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] cnt
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_pop;

   // storage write, pointer wrap and occupancy update; pop of an empty FIFO is ignored
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop && (cnt_q != '0);
      if (push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
   end

   // state registers; storage is cleared so the head reads zero after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign cnt      = cnt_q;
endmodule

// ifu_mt: multi-thread fetch unit, round-robin thread pick, tagged in-order fetches, instruction queue.
// Latency: reset release -> first request 1 cycle; response -> decode valid 1 cycle later.
// Backpressure: request held while req_ready=0; issue stops when outstanding+queued would exceed the IQ.
module ifu_mt #(
   parameter int  NUM_THREADS = 4,
   localparam int TID_W       = $clog2(NUM_THREADS),
   parameter int  XLEN        = 32,
   parameter int  ADDR_LEN    = 15,
   localparam int PC_W        = ADDR_LEN - TID_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int  MAX_OUT     = 4,
   parameter int  IQ_DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_THREADS-1:0] thread_en,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [ADDR_LEN-1:0]    req_addr,
   input  logic                   rsp_valid,
   input  logic [XLEN-1:0]        rsp_data,
   input  logic                   redir_valid,
   input  logic [TID_W-1:0]       redir_tid,
   input  logic [PC_W-1:0]        redir_pc,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [XLEN-1:0]        dec_instr,
   output logic [PC_W-1:0]        dec_pc,
   output logic [TID_W-1:0]       dec_tid
);
   localparam int TCW = $clog2(MAX_OUT + 1);
   localparam int ICW = $clog2(IQ_DEPTH + 1);

   typedef struct packed {
      logic [TID_W-1:0] tid;
      logic [PC_W-1:0]  pc;
      logic [1:0]       epoch;
   } tag_t;

   typedef struct packed {
      tag_t            tag;
      logic [XLEN-1:0] instr;
   } iq_ent_t;

   logic [PC_W-1:0]     pc_q    [NUM_THREADS];
   logic [PC_W-1:0]     pc_d    [NUM_THREADS];
   logic [1:0]          epoch_q [NUM_THREADS];
   logic [1:0]          epoch_d [NUM_THREADS];
   logic [TID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                req_valid_q, req_valid_d;
   logic [ADDR_LEN-1:0] req_addr_q, req_addr_d;
   logic [1:0]          req_epoch_q, req_epoch_d;

   logic                gnt_vld, credit_ok, hs;
   logic [TID_W-1:0]    gnt_tid, cand;
   tag_t                tag_push, tag_head;
   iq_ent_t             iq_push_dat, iq_head;
   logic [TCW-1:0]      tag_cnt;
   logic [ICW-1:0]      iq_cnt;
   logic                iq_push, iq_pop, head_fresh;

   assign hs        = req_valid_q && req_ready;
   // a slot in the IQ is reserved for every outstanding fetch and for the pending request
   assign credit_ok = (int'(tag_cnt) + int'(iq_cnt) + int'(req_valid_q) < IQ_DEPTH) &&
                      (int'(tag_cnt) < MAX_OUT);

   // round-robin pick, request register, per-thread PC and epoch update; redirect applied last so its PC wins
   always_comb begin
      pc_d        = pc_q;
      epoch_d     = epoch_q;
      rr_ptr_d    = rr_ptr_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_epoch_d = req_epoch_q;
      gnt_vld     = 1'b0;
      gnt_tid     = '0;
      cand        = '0;
      for (int i = 1; i <= NUM_THREADS; i++) begin
         cand = rr_ptr_q + TID_W'(i);
         if (!gnt_vld && thread_en[cand]) begin
            gnt_vld = 1'b1;
            gnt_tid = cand;
         end
      end
      if (!req_valid_q || req_ready) begin
         if (gnt_vld && credit_ok) begin
            req_valid_d      = 1'b1;
            req_addr_d       = {gnt_tid, pc_q[gnt_tid]};
            // epoch is captured at grant so a same-cycle redirect marks this fetch stale
            req_epoch_d      = epoch_q[gnt_tid];
            pc_d[gnt_tid]    = pc_q[gnt_tid] + PC_W'(1);
            rr_ptr_d         = gnt_tid;
         end else begin
            req_valid_d = 1'b0;
         end
      end
      if (redir_valid) begin
         pc_d[redir_tid]    = redir_pc;
         epoch_d[redir_tid] = epoch_q[redir_tid] + 2'd1;
      end
   end

   // fetch state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t]    <= RESET_PC;
            epoch_q[t] <= '0;
         end
         rr_ptr_q    <= TID_W'(NUM_THREADS - 1);
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_epoch_q <= '0;
      end else begin
         pc_q        <= pc_d;
         epoch_q     <= epoch_d;
         rr_ptr_q    <= rr_ptr_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_epoch_q <= req_epoch_d;
      end
   end

   // response filtering and IQ head handling: stale entries are discarded, one per cycle at the head
   always_comb begin
      tag_push.tid      = req_addr_q[ADDR_LEN-1 -: TID_W];
      tag_push.pc       = req_addr_q[PC_W-1:0];
      tag_push.epoch    = req_epoch_q;
      iq_push_dat.tag   = tag_head;
      iq_push_dat.instr = rsp_data;
      iq_push           = rsp_valid && (tag_cnt != '0) && (tag_head.epoch == epoch_q[tag_head.tid]);
      head_fresh        = iq_head.tag.epoch == epoch_q[iq_head.tag.tid];
      dec_valid         = (iq_cnt != '0) && head_fresh;
      iq_pop            = (dec_valid && dec_ready) || ((iq_cnt != '0) && !head_fresh);
   end

   ifu_fifo #(.W($bits(tag_t)), .DEPTH(MAX_OUT)) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (hs),
      .push_dat (tag_push),
      .pop      (rsp_valid),
      .head_dat (tag_head),
      .cnt      (tag_cnt)
   );

   ifu_fifo #(.W($bits(iq_ent_t)), .DEPTH(IQ_DEPTH)) u_iq (
      .clk      (clk),
      .rst      (rst),
      .push     (iq_push),
      .push_dat (iq_push_dat),
      .pop      (iq_pop),
      .head_dat (iq_head),
      .cnt      (iq_cnt)
   );

   assign req_valid = req_valid_q;
   assign req_addr  = req_addr_q;
   assign dec_instr = iq_head.instr;
   assign dec_pc    = iq_head.tag.pc;
   assign dec_tid   = iq_head.tag.tid;

   // a response with nothing outstanding means the memory side broke the protocol
   a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst) rsp_valid |-> (tag_cnt != '0));
endmodule
